// File: rtl/cursor_datapath.sv
// X/Y cursor position datapath: synchronised active-low buttons drive
// stepped moves inside a W x H canvas, with hold-to-repeat and home.
module cursor_datapath #(
    parameter int X_MAX         = 160,
    parameter int Y_MAX         = 120,
    parameter int COORD_W       = 8,
    parameter int STEP_W        = 4,
    parameter int TIMER_W       = 26,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [3:0]         key_n,
    input  logic               wrap_mode,
    input  logic               home,
    input  logic [STEP_W-1:0]  step,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic               moved
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [COORD_W:0]   LP_XLIM    = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0]   LP_YLIM    = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W-1:0] LP_XHOME   = COORD_W'(X_MAX / 2);
    localparam logic [COORD_W-1:0] LP_YHOME   = COORD_W'(Y_MAX / 2);
    localparam logic [TIMER_W-1:0] LP_DLY_END = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] LP_PER_END = TIMER_W'(REPEAT_PERIOD - 1);

    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [3:0]         r_prev_dir;
    logic [1:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [COORD_W-1:0] r_xpos;
    logic [COORD_W-1:0] r_ypos;
    logic               r_moved;

    logic [3:0]         w_pressed;
    logic [3:0]         w_dir;
    logic               w_active;
    logic               w_do_step;
    logic [1:0]         w_state_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [COORD_W:0]   w_step_ext;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;

    // One axis move; intermediates are one bit wider so p+step never overflows.
    function automatic logic [COORD_W-1:0] f_axis(
        input logic [COORD_W-1:0] pos,
        input logic               inc,
        input logic               dec,
        input logic [COORD_W:0]   stp,
        input logic [COORD_W:0]   lim,
        input logic               wrap
    );
        logic [COORD_W:0] p;
        logic [COORD_W:0] sum;
        logic [COORD_W:0] res;
        p   = {1'b0, pos};
        sum = p + stp;
        res = p;
        if (inc) begin
            if (sum >= lim) res = wrap ? (sum - lim) : (lim - 1'b1);
            else            res = sum;
        end else if (dec) begin
            if (p < stp) res = wrap ? (p + lim - stp) : '0;
            else         res = p - stp;
        end
        return COORD_W'(res);
    endfunction

    always_comb begin
        w_pressed  = ~r_sync2;
        w_dir      = {w_pressed[0] & ~w_pressed[1], w_pressed[1] & ~w_pressed[0],
                      w_pressed[2] & ~w_pressed[3], w_pressed[3] & ~w_pressed[2]};
        w_active   = |w_dir;
        w_step_ext = (COORD_W+1)'(step);
        w_x_nxt    = f_axis(r_xpos, w_dir[3], w_dir[2], w_step_ext, LP_XLIM, wrap_mode);
        w_y_nxt    = f_axis(r_ypos, w_dir[1], w_dir[0], w_step_ext, LP_YLIM, wrap_mode);
    end

    always_comb begin
        w_do_step   = 1'b0;
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
        if (en && w_active) begin
            case (r_state)
                S_IDLE: begin
                    w_do_step   = 1'b1;
                    w_state_nxt = S_DELAY;
                end
                S_DELAY, S_REPEAT: begin
                    if (w_dir != r_prev_dir) begin
                        w_do_step   = 1'b1;
                        w_state_nxt = S_DELAY;
                    end else if (r_timer == ((r_state == S_DELAY) ? LP_DLY_END : LP_PER_END)) begin
                        w_do_step   = 1'b1;
                        w_state_nxt = S_REPEAT;
                    end else begin
                        w_state_nxt = r_state;
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_prev_dir <= '0;
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_xpos     <= '0;
            r_ypos     <= '0;
            r_moved    <= 1'b0;
        end else begin
            r_sync1    <= key_n;
            r_sync2    <= r_sync1;
            r_prev_dir <= w_dir;
            if (home) begin
                r_state <= S_IDLE;
                r_timer <= '0;
                r_xpos  <= LP_XHOME;
                r_ypos  <= LP_YHOME;
                r_moved <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_timer <= w_timer_nxt;
                r_moved <= w_do_step && ((w_x_nxt != r_xpos) || (w_y_nxt != r_ypos));
                if (w_do_step) begin
                    r_xpos <= w_x_nxt;
                    r_ypos <= w_y_nxt;
                end
            end
        end
    end

    assign xpos  = r_xpos;
    assign ypos  = r_ypos;
    assign moved = r_moved;

endmodule

// File: tb/tb_cursor_datapath.sv
// Self-checking bench for cursor_datapath: directed scenarios plus random
// stimulus, all compared every cycle against a run-age based reference model.
module tb_cursor_datapath;

    localparam int XM = 160;
    localparam int YM = 120;
    localparam int RD = 8;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic       wrap_mode = 1'b0;
    logic       home = 1'b0;
    logic [3:0] step = 4'd1;
    logic [7:0] xpos;
    logic [7:0] ypos;
    logic       moved;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulse  = 0;

    // Reference model state: two-edge input delay line plus run age.
    logic [3:0] m_h1, m_h2;
    int m_x, m_y, m_age, m_pdx, m_pdy;
    bit m_moved, m_run;

    cursor_datapath #(
        .X_MAX(XM), .Y_MAX(YM), .COORD_W(8), .STEP_W(4), .TIMER_W(26),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .key_n(key_n),
        .wrap_mode(wrap_mode), .home(home), .step(step),
        .xpos(xpos), .ypos(ypos), .moved(moved)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int axis(input int p, input int d, input int s, input int mx, input bit wr);
        int v;
        v = p + d * s;
        if (wr) return ((v % mx) + mx) % mx;
        if (v < 0) return 0;
        if (v > mx - 1) return mx - 1;
        return v;
    endfunction

    task automatic model_reset();
        m_h1 = 4'hF; m_h2 = 4'hF;
        m_x = 0; m_y = 0; m_moved = 0; m_run = 0;
        m_age = 0; m_pdx = 0; m_pdy = 0;
    endtask

    task automatic model_edge();
        logic [3:0] pr;
        int dx, dy, nx, ny;
        bit fire;
        if (reset) begin
            model_reset();
            return;
        end
        pr = ~m_h2; m_h2 = m_h1; m_h1 = key_n;
        dx = int'(pr[0]) - int'(pr[1]);
        dy = int'(pr[2]) - int'(pr[3]);
        m_moved = 0;
        if (home) begin
            m_x = XM / 2; m_y = YM / 2; m_run = 0;
        end else if (!en || (dx == 0 && dy == 0)) begin
            m_run = 0;
        end else begin
            if (!m_run || dx != m_pdx || dy != m_pdy) begin
                m_run = 1; m_age = 0;
            end else begin
                m_age++;
            end
            fire = (m_age == 0) || (m_age == RD) || (m_age > RD && (m_age - RD) % RP == 0);
            if (fire) begin
                nx = axis(m_x, dx, int'(step), XM, wrap_mode);
                ny = axis(m_y, dy, int'(step), YM, wrap_mode);
                m_moved = (nx != m_x) || (ny != m_y);
                m_x = nx; m_y = ny;
            end
        end
        m_pdx = dx; m_pdy = dy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (moved) n_pulse++;
        check_val("xpos", int'(xpos), m_x);
        check_val("ypos", int'(ypos), m_y);
        check_val("moved", int'(moved), int'(m_moved));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tap(input logic [3:0] k);
        key_n = k;
        tick();
        key_n = 4'hF;
        ticks(3);
    endtask

    task automatic wait_moved(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (moved) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_home();
        home = 1'b1;
        tick();
        home = 1'b0;
    endtask

    initial begin
        int lat;
        int sx, sy;
        model_reset();
        ticks(2);
        check_val("reset_x", int'(xpos), 0);
        check_val("reset_y", int'(ypos), 0);
        check_val("reset_moved", int'(moved), 0);
        reset = 1'b0;
        ticks(2);

        // saturate at left edge
        n_pulse = 0;
        tap(4'b1101);
        check_val("sat_left_x", int'(xpos), 0);
        check_val("sat_left_pulses", n_pulse, 0);

        // hold x+ 30 cycles: moves at edges 3, 11, 15, 19, 23, 27
        n_pulse = 0;
        key_n = 4'b1110;
        ticks(30);
        check_val("hold_pulses", n_pulse, 6);
        check_val("hold_x", int'(xpos), 6);
        key_n = 4'hF;
        ticks(5);

        // build ypos 118 and xpos 158 from home
        do_home();
        step = 4'd10;
        for (int i = 0; i < 5; i++) tap(4'b1011);
        step = 4'd8;
        tap(4'b1011);
        check_val("y_118", int'(ypos), 118);
        step = 4'd13;
        for (int i = 0; i < 6; i++) tap(4'b1110);
        check_val("x_158", int'(xpos), 158);
        step = 4'd3;
        tap(4'b1110);
        check_val("sat_right_x", int'(xpos), 159);
        step = 4'd1;
        tap(4'b1101);
        check_val("x_back_158", int'(xpos), 158);

        wrap_mode = 1'b1;
        step = 4'd3;
        tap(4'b1110);
        check_val("wrap_xplus", int'(xpos), 1);
        tap(4'b1101);
        check_val("wrap_xminus", int'(xpos), 158);
        tap(4'b1011);
        check_val("wrap_yplus", int'(ypos), 1);
        wrap_mode = 1'b0;
        step = 4'd1;

        // opposing keys cancel; then diagonal tap
        do_home();
        n_pulse = 0;
        key_n = 4'b1100;
        ticks(6);
        check_val("cancel_x", int'(xpos), 80);
        check_val("cancel_pulses", n_pulse, 0);
        key_n = 4'hF;
        ticks(3);
        n_pulse = 0;
        tap(4'b1010);
        check_val("diag_x", int'(xpos), 81);
        check_val("diag_y", int'(ypos), 61);
        check_val("diag_pulses", n_pulse, 1);

        // direction change while repeating restarts the delay
        do_home();
        key_n = 4'b1110;
        ticks(19);
        key_n = 4'b1010;
        wait_moved(10, lat);
        check_val("dirchg_latency", lat, 3);
        wait_moved(20, lat);
        check_val("dirchg_next", lat, RD);
        do_home();
        check_val("home_x", int'(xpos), 80);
        check_val("home_y", int'(ypos), 60);
        check_val("home_moved", int'(moved), 0);
        key_n = 4'hF;
        ticks(4);

        // async reset mid-hold
        key_n = 4'b1110;
        ticks(20);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_x", int'(xpos), 0);
        check_val("async_rst_y", int'(ypos), 0);
        tick();
        reset = 1'b0;
        wait_moved(10, lat);
        check_val("post_reset_latency", lat, 3);
        key_n = 4'hF;
        ticks(4);

        // en low freezes motion
        en = 1'b0;
        sx = m_x; sy = m_y;
        n_pulse = 0;
        key_n = 4'b0110;
        ticks(20);
        check_val("en0_x", int'(xpos), sx);
        check_val("en0_y", int'(ypos), sy);
        check_val("en0_pulses", n_pulse, 0);
        en = 1'b1;
        key_n = 4'hF;
        ticks(4);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 6) == 0) key_n = 4'($urandom);
            if ($urandom_range(0, 9) == 0) wrap_mode = 1'($urandom);
            if ($urandom_range(0, 4) == 0) step = 4'($urandom_range(0, 15));
            en   = ($urandom_range(0, 19) != 0);
            home = ($urandom_range(0, 60) == 0);
            tick();
        end
        home = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cursor_datapath.md
Name: cursor_datapath

Overview:
- Parametrised successor to the etch-a-sketch X/Y position datapath.
- Converts four active-low push-button inputs into X/Y cursor coordinates inside a configurable W x H canvas.
- Adds: programmable step size, saturate or wrap edge mode, synchronous home, and hold-to-auto-repeat using an internal delay/period timer.
- Feeds the VGA plot address path; the top-level FSM gates it with en.

Parameters:
X_MAX, 160, canvas width; xpos range 0..X_MAX-1
Y_MAX, 120, canvas height; ypos range 0..Y_MAX-1
COORD_W, 8, coordinate width; 2^COORD_W >= max(X_MAX,Y_MAX)
STEP_W, 4, width of step input
TIMER_W, 26, width of repeat timer
REPEAT_DELAY, 25000000, cycles from first move to first auto-repeat move (>=2)
REPEAT_PERIOD, 5000000, cycles between auto-repeat moves (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  movement enable
key_n  input  4  active-low buttons: [0] x+, [1] x-, [2] y+, [3] y-
wrap_mode  input  1  0 = saturate at edges, 1 = wrap modulo canvas size
home  input  1  synchronous load of canvas centre
step  input  STEP_W  move distance per step; 0 = no motion; must be <= min(X_MAX,Y_MAX)
xpos  output  COORD_W  current X coordinate
ypos  output  COORD_W  current Y coordinate
moved  output  1  one-cycle pulse when xpos or ypos changed due to a step

Behaviour:
- Reset (async, active-high): xpos=0, ypos=0, moved=0, FSM=IDLE, timer=0, synchroniser flops=1 (released).
- key_n passes through a 2-flop synchroniser; pressed = ~synced.
- Axis direction: dx=+1 if x+ only, -1 if x- only, 0 if neither or both; dy likewise. dir_vec={dx,dy}; active = dir_vec nonzero.
- Latency: a key asserted before edge N moves the position at edge N+3 (2 sync + decision); moved is high in the same cycle the new position is visible.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE: on active and en, step once, timer=0, go to DELAY.
  - DELAY: timer increments; at timer==REPEAT_DELAY-1, step, timer=0, go to REPEAT.
  - REPEAT: at timer==REPEAT_PERIOD-1, step, timer=0.
  - Any state: active falls, go to IDLE with timer=0, no step.
  - DELAY/REPEAT: dir_vec differs from the previous cycle while still active, step immediately, timer=0, go to DELAY.
  - en low: no step, go to IDLE, timer=0; position holds.
- Step arithmetic uses COORD_W+1-bit intermediates; both axes update on the same edge.
  - Saturate, add: result = min(p+step, MAX-1).
  - Saturate, sub: result = 0 if p<step, else p-step.
  - Wrap, add: result = p+step-MAX if p+step>=MAX, else p+step.
  - Wrap, sub: result = p+MAX-step if p<step, else p-step.
- moved=1 only if a step occurs and at least one coordinate changes. Pinned at an edge in saturate mode, or step=0, gives moved=0.
- home: at the next edge, xpos=X_MAX/2 and ypos=Y_MAX/2 (integer divide), FSM=IDLE, timer=0, moved=0. home has priority over a simultaneous step. Held keys restart from IDLE once home drops.
- wrap_mode and step are sampled at the step edge; changing them mid-hold does not restart the timer.
- Reset asserted mid-hold aborts immediately to reset values. After release, a still-held key acts as a new press (3-cycle latency).

Test Plan:
- Params X_MAX=160, Y_MAX=120, REPEAT_DELAY=8, REPEAT_PERIOD=4, step=1, saturate. Hold key_n[0] low 30 cycles -> xpos 0->1 at edge 3, 2 at edge 11, then +1 every 4 cycles; 6 moved pulses; xpos=6.
- xpos=0, press x- (saturate) -> xpos stays 0, moved never pulses. xpos=158, step=3, x+ -> xpos=159.
- wrap_mode=1, step=3: xpos=158 with x+ -> 1; xpos=1 with x- -> 158; ypos=118 with y+ -> 1.
- key_n=4'b1100 (x+ and x- both pressed) -> xpos unchanged, FSM stays IDLE. Then key_n=4'b1010 (x+, y+) -> xpos and ypos both +1 on the same edge, single moved pulse.
- Holding x+ in REPEAT, switch to x+ and y+ -> immediate diagonal step, next step after 8 cycles. Assert home -> (80,60), moved=0.
- Assert reset asynchronously mid-cycle during REPEAT -> xpos=ypos=0 before the next edge. en=0 with keys held -> no motion.
